// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline-stage registers: stage state encoding,
// default widths and the bubble (NOP) payload.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam int unsigned PIPE_DATA_W = 64;
    localparam int unsigned PIPE_CNT_W  = 16;

    // Bubble payload loaded on reset/flush; all-zero decodes as a NOP.
    localparam logic [PIPE_DATA_W-1:0] PIPE_NOP = '0;

    function automatic logic [1:0] occupancy_of(input state_t s);
        case (s)
            ST_BUSY: return 2'd1;
            ST_FULL: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; shared by the pipeline
// performance counters.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline stage register with a two-entry skid buffer,
// synchronous flush to a bubble pattern and a saturating stall counter.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W         = PIPE_DATA_W,
    parameter logic [DATA_W-1:0] FLUSH_DATA     = {DATA_W{1'b0}},
    parameter bit                CLEAR_ON_FLUSH = 1'b1,
    parameter int unsigned       CNT_W          = PIPE_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_cnt_clr
);

    state_t            state, state_n;
    logic [DATA_W-1:0] main_q, main_n;
    logic [DATA_W-1:0] skid_q, skid_n;

    always_comb begin
        state_n = state;
        main_n  = main_q;
        skid_n  = skid_q;
        if (flush) begin
            state_n = ST_EMPTY;
            if (CLEAR_ON_FLUSH) begin
                main_n = FLUSH_DATA;
                skid_n = FLUSH_DATA;
            end
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_valid) begin
                        main_n  = in_data;
                        state_n = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (in_valid && out_ready) begin
                        main_n = in_data;
                    end else if (in_valid) begin
                        skid_n  = in_data;
                        state_n = ST_FULL;
                    end else if (out_ready) begin
                        state_n = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so any in_valid is ignored
                    if (out_ready) begin
                        main_n  = skid_q;
                        state_n = ST_BUSY;
                    end
                end
                default: state_n = ST_EMPTY;
            endcase
        end
    end

    // Handshake outputs are registered from the next state so nothing
    // combinational reaches them from the inputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_EMPTY;
            main_q    <= FLUSH_DATA;
            skid_q    <= FLUSH_DATA;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            occupancy <= 2'd0;
        end else begin
            state     <= state_n;
            main_q    <= main_n;
            skid_q    <= skid_n;
            out_valid <= (state_n != ST_EMPTY);
            in_ready  <= (state_n != ST_FULL);
            occupancy <= occupancy_of(state_n);
        end
    end

    assign out_data = main_q;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (out_valid && !out_ready),
        .clr   (stall_cnt_clr),
        .count (stall_cnt)
    );

    a_ready_not_full: assert property (
        @(posedge clk) disable iff (!reset) !(state == ST_FULL && in_ready)
    );

    a_occupancy_state: assert property (
        @(posedge clk) disable iff (!reset) occupancy == occupancy_of(state)
    );

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
Parametrised pipeline-stage register that replaces fixed enable/flush stage registers such as IF/ID and ID/EX. Uses a valid/ready handshake with a two-entry skid buffer, so upstream back-pressure (in_ready) is fully registered and the stage sustains one transfer per cycle. Supports synchronous flush to a programmable bubble pattern (NOP). Keeps a saturating stall-cycle counter for pipeline performance analysis.

Parameters:
DATA_W, 64, payload width in bits (e.g. PC + instruction = 64).
FLUSH_DATA, {DATA_W{1'b0}}, payload value loaded on reset/flush (the bubble pattern; all-zero = NOP).
CLEAR_ON_FLUSH, 1, 1: flush loads FLUSH_DATA into both entries; 0: flush clears valid only, data retained.
CNT_W, 16, stall counter width.

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
flush  input  1  synchronous flush, discards all held entries
in_valid  input  1  upstream offers in_data
in_ready  output  1  stage can accept this cycle (registered)
in_data  input  DATA_W  upstream payload
out_valid  output  1  out_data is valid
out_ready  input  1  downstream accepts out_data this cycle
out_data  output  DATA_W  payload, driven directly from main register
occupancy  output  2  entries held: 0, 1 or 2
stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
stall_cnt_clr  input  1  synchronous clear of stall_cnt

Behaviour:
- Storage: main register (drives out_data) and skid register. State machine EMPTY (0 entries), BUSY (main only), FULL (main + skid).
- Reset (reset=0, asynchronous): state=EMPTY, main=skid=FLUSH_DATA, out_valid=0, in_ready=1, occupancy=0, stall_cnt=0.
- Outputs are all register-driven: out_valid=(state!=EMPTY), in_ready=(state!=FULL), occupancy from state. No combinational in->out paths.
- Transfer in = in_valid&in_ready; transfer out = out_valid&out_ready.
- EMPTY: in_valid -> main<=in_data, go BUSY. Otherwise hold.
- BUSY: in_valid&out_ready -> main<=in_data, stay BUSY. in_valid&!out_ready -> skid<=in_data, go FULL. !in_valid&out_ready -> go EMPTY; main retains its value. Neither -> hold.
- FULL: out_ready -> main<=skid, go BUSY; in_ready=0, so in_valid is ignored. !out_ready -> hold everything.
- Latency: 1 cycle from in transfer to out_valid when EMPTY. Throughput: 1 transfer per cycle in steady state. Ordering: strict FIFO, no drop or duplication.
- flush=1 (priority over all handshake activity, below reset):
  - next state EMPTY; in_data is not captured that cycle even if in_valid=1.
  - if CLEAR_ON_FLUSH=1, main and skid are loaded with FLUSH_DATA.
  - out transfer in the flush cycle still counts as consumed downstream; the stage does not re-present it.
- stall_cnt:
  - +1 per cycle with out_valid&!out_ready; saturates at 2^CNT_W-1 with no wrap.
  - stall_cnt_clr takes priority over increment and loads 0.
  - flush does not affect stall_cnt; only reset and stall_cnt_clr clear it.
- Reset asserted mid-transfer: state and data clear immediately, independent of clk. Deassertion is synchronised externally.
- Assertions for the verifier:
  - in_valid held with stable in_data until accepted (upstream obligation).
  - state never FULL while in_ready=1.
  - occupancy equals number of accepted minus delivered entries since last flush/reset.

Decomposition:
- Shared package pipe_pkg: state encoding constants (ST_EMPTY=2'd0, ST_BUSY=2'd1, ST_FULL=2'd2), NOP instruction constant for FLUSH_DATA, default widths.
- One natural sub-module: sat_counter (CNT_W, inc, clr, count), reused for other performance counters.
- Skid logic stays in the top module.

Test Plan:
1. Reset then stream, out_ready=1: in_data=1..8 on consecutive cycles -> out_data 1..8 one cycle later each; in_ready stays 1; occupancy stays ≤1; stall_cnt=0.
2. Back-pressure: send A,B; out_ready=0 for 3 cycles -> occupancy 2; in_ready=0 from cycle after B; stall_cnt=3. Then out_ready=1 -> A then B delivered in order; in_ready returns to 1.
3. Flush while FULL (A,B held, in_valid=1 with C): flush=1 one cycle -> out_valid=0, occupancy=0; out_data=0 (CLEAR_ON_FLUSH=1); C not captured; next in D appears as first output.
4. CLEAR_ON_FLUSH=0, DATA_W=32: hold 0xDEADBEEF, flush -> out_valid=0; out_data remains 0xDEADBEEF.
5. CNT_W=2: 6 stalled cycles -> stall_cnt 1,2,3,3,3,3. Then stall_cnt_clr together with a stall cycle -> 0.
6. Asynchronous reset pulsed between clk edges while FULL -> out_valid, occupancy, stall_cnt go to 0 and in_ready goes to 1 immediately, before the next edge.
